// File: rtl/data_mem_lsu.sv
// MEM-stage load/store unit: turns one load or store into a single word-addressed
// bus transaction with byte enables, stalls until it completes, and aligns/extends load data.
module data_mem_lsu #(
    parameter int BUS_AW = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [1:0]        i_rw_sz,
    input  logic              i_sign_ext,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_stall,
    output logic [31:0]       o_rdata,
    output logic              o_rdata_valid,
    output logic              o_misaligned,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [BUS_AW-1:0] o_bus_addr,
    output logic [3:0]        o_bus_be,
    output logic [31:0]       o_bus_wdata,
    input  logic              i_bus_gnt,
    input  logic              i_bus_rvalid,
    input  logic [31:0]       i_bus_rdata
);

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HWORD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic              req_s;
    logic              mis_s;
    logic              stall_s;
    logic              capture_req_s;
    logic              capture_rd_s;
    logic [1:0]        off_r;
    logic [1:0]        size_r;
    logic              sext_r;
    logic              we_r;
    logic [3:0]        be_r;
    logic [31:0]       wdata_r;
    logic [BUS_AW-1:0] addr_r;
    logic [31:0]       rdata_r;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE:  return 1'b0;
            SZ_HWORD: return a[0];
            default:  return (a != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE:  return 4'b0001 << a;
            SZ_HWORD: return 4'b0011 << a;
            default:  return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            SZ_BYTE:  return {4{wd[7:0]}};
            SZ_HWORD: return {2{wd[15:0]}};
            default:  return wd;
        endcase
    endfunction

    function automatic logic [31:0] extend_rdata(input logic [1:0] sz, input logic [1:0] a,
                                                 input logic sx, input logic [31:0] rd);
        logic [31:0] s;
        s = rd >> {a, 3'b000};
        case (sz)
            SZ_BYTE:  return {{24{sx & s[7]}}, s[7:0]};
            SZ_HWORD: return {{16{sx & s[15]}}, s[15:0]};
            default:  return s;
        endcase
    endfunction

    assign req_s = i_mem_read | i_mem_write;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode, stall/misalign indication and capture strobes.
    always_comb begin
        next_state_s  = state_r;
        stall_s       = 1'b0;
        mis_s         = 1'b0;
        capture_req_s = 1'b0;
        capture_rd_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s && is_misaligned(i_rw_sz, i_addr[1:0])) begin
                    mis_s = 1'b1;
                end else if (req_s) begin
                    stall_s       = 1'b1;
                    capture_req_s = 1'b1;
                    next_state_s  = ST_REQ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                stall_s = 1'b1;
                if (i_bus_gnt && we_r) begin
                    next_state_s = ST_DONE;
                end else if (i_bus_gnt && i_bus_rvalid) begin
                    capture_rd_s = 1'b1;
                    next_state_s = ST_DONE;
                end else if (i_bus_gnt) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                stall_s = 1'b1;
                if (i_bus_rvalid) begin
                    capture_rd_s = 1'b1;
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            // The same instruction is still on the inputs here, so it must not re-issue.
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Request capture and load-data capture; bus fields stay stable while in REQ.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            off_r   <= 2'b00;
            size_r  <= 2'b00;
            sext_r  <= 1'b0;
            we_r    <= 1'b0;
            be_r    <= 4'b0000;
            wdata_r <= 32'h0000_0000;
            addr_r  <= '0;
            rdata_r <= 32'h0000_0000;
        end else begin
            if (capture_req_s) begin
                off_r   <= i_addr[1:0];
                size_r  <= i_rw_sz;
                sext_r  <= i_sign_ext;
                we_r    <= i_mem_write & ~i_mem_read;
                be_r    <= byte_en(i_rw_sz, i_addr[1:0]);
                wdata_r <= lane_wdata(i_rw_sz, i_wdata);
                addr_r  <= {i_addr[BUS_AW-1:2], 2'b00};
            end
            if (capture_rd_s) begin
                rdata_r <= extend_rdata(size_r, off_r, sext_r, i_bus_rdata);
            end
        end
    end

    assign o_stall       = stall_s;
    assign o_misaligned  = mis_s;
    assign o_bus_req     = (state_r == ST_REQ);
    assign o_rdata_valid = (state_r == ST_DONE) & ~we_r;
    assign o_rdata       = rdata_r;
    assign o_bus_we      = we_r;
    assign o_bus_addr    = addr_r;
    assign o_bus_be      = be_r;
    assign o_bus_wdata   = wdata_r;

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Load/store unit in the MEM stage. It is the responder for the memory control fields the decoder emits: mem_read, mem_write, rw_sz and sign_ext.
- Turns each load or store into a single 32-bit word-addressed bus transaction with byte enables.
- Stalls the pipeline until the transaction completes.
- Returns load data that has been lane-aligned and zero- or sign-extended.

Parameters:
- BUS_AW, 32, bus address width. o_bus_addr[1:0] is always 0.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_mem_read  in  1  load request (mem_ctrl.mem_read)
- i_mem_write  in  1  store request (mem_ctrl.mem_write)
- i_rw_sz  in  rw_sz type  access size BYTE/HWORD/WORD (rv_pkg encoding)
- i_sign_ext  in  1  sign-extend load result
- i_addr  in  32  byte address (ALU result)
- i_wdata  in  32  store data (rs2)
- o_stall  out  1  hold the pipeline
- o_rdata  out  32  extended load result
- o_rdata_valid  out  1  o_rdata valid, 1-cycle pulse
- o_misaligned  out  1  misaligned access, 1-cycle pulse
- o_bus_req  out  1  bus request
- o_bus_we  out  1  1 = write
- o_bus_addr  out  BUS_AW  word address, {i_addr[31:2],2'b00}
- o_bus_be  out  4  byte enables
- o_bus_wdata  out  32  lane-replicated write data
- i_bus_gnt  in  1  request accepted this cycle
- i_bus_rvalid  in  1  read data valid
- i_bus_rdata  in  32  read data word

Behaviour:
- Reset (async, active-low):
  - state = IDLE.
  - All outputs, including the registered bus signals, are 0.
  - All captured request fields are cleared.
- States: IDLE, REQ, WAIT, DONE.
- Request present: req = i_mem_read | i_mem_write. If both are high, the access is treated as a read.
- Misaligned:
  - HWORD with addr[0] = 1, or WORD with addr[1:0] != 0.
  - Evaluated in IDLE.
- IDLE:
  - Misaligned req: o_misaligned = 1 in that cycle (combinational); o_stall = 0; no bus activity; stay in IDLE.
  - Aligned req: o_stall = 1 combinationally. Capture addr[1:0], size, sign_ext, we, be and wdata. Go to REQ.
  - No req: o_stall = 0.
- REQ:
  - o_bus_req = 1 and o_stall = 1.
  - Bus signals are held stable until i_bus_gnt.
  - On gnt with a write: go to DONE.
  - On gnt with a read and i_bus_rvalid in the same cycle: capture data, go to DONE.
  - On gnt with a read otherwise: go to WAIT.
- WAIT:
  - o_stall = 1 and o_bus_req = 0.
  - On i_bus_rvalid: capture the extended data, go to DONE.
- DONE:
  - o_stall = 0. For reads, o_rdata_valid = 1.
  - Inputs are ignored, because the same instruction is still presented this cycle. Go to IDLE.
  - Latency for an aligned access is 3 cycles minimum (IDLE→REQ→DONE) with 0-wait gnt and same-cycle rvalid.
- i_bus_gnt and i_bus_rvalid are ignored in IDLE and DONE. This covers stale responses after a reset.
- Byte enables:
  - BYTE: 4'b0001 << a.
  - HWORD: 4'b0011 << a.
  - WORD: 4'b1111.
  - Here a = addr[1:0].
- Write data:
  - BYTE: {4{wdata[7:0]}}.
  - HWORD: {2{wdata[15:0]}}.
  - WORD: wdata.
- Read data:
  - s = i_bus_rdata >> (8*a).
  - BYTE: ext(s[7:0]). HWORD: ext(s[15:0]). WORD: s.
  - ext is sign extension when sign_ext = 1, otherwise zero extension.
- o_rdata holds its value until the next capture. o_rdata_valid is high only in DONE for a read.
- Reset mid-transaction aborts immediately: o_bus_req drops and no o_rdata_valid is produced.

Test Plan:
- LB, addr 0x103, sign_ext = 1, rdata 0x80FF_1234, gnt and rvalid 1 cycle after REQ → o_bus_be = 4'b1000, addr 0x100, o_rdata = 0xFFFF_FF80, o_stall high for exactly 2 cycles.
- LHU, addr 0x2, rdata 0x8001_0000, gnt delayed 3 cycles, rvalid 2 cycles later → o_rdata = 0x0000_8001, bus signals stable throughout REQ, stall drops in DONE.
- SB, addr 0x1, wdata 0x1234_56AB, immediate gnt → o_bus_we = 1, be = 4'b0010, wdata = 0xABAB_ABAB, no o_rdata_valid.
- LW, addr 0x6 → o_misaligned pulse, o_stall = 0, o_bus_req never asserted. SH, addr 0x3 → same response.
- Back-to-back SW 0x10 then LW 0x10 → two separate bus transactions; DONE does not re-issue; no lost or duplicate request.
- i_rst_n low while in WAIT, then a stray rvalid after reset → outputs 0, state IDLE, rvalid ignored, no o_rdata_valid.
